// File: rtl/jzjpcc_scoreboard_hazard_unit.sv
// Register scoreboard and hazard unit: tracks long-latency destinations, generates stalls/flushes and EX bypass selects.
// Optional watchdog enabled by defining JZJPCC_SCOREBOARD_TIMEOUT_EN.
module jzjpcc_scoreboard_hazard_unit #(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [REG_ADDR_WIDTH-1:0]              rs1Addr_decode,
    input  logic [REG_ADDR_WIDTH-1:0]              rs2Addr_decode,
    input  logic [REG_ADDR_WIDTH-1:0]              rdAddr_decode,
    input  logic [REG_ADDR_WIDTH-1:0]              rs1Addr_execute,
    input  logic [REG_ADDR_WIDTH-1:0]              rs2Addr_execute,
    input  logic [REG_ADDR_WIDTH-1:0]              rdAddr_execute,
    input  logic [REG_ADDR_WIDTH-1:0]              rdAddr_memory,
    input  logic [REG_ADDR_WIDTH-1:0]              rdAddr_writeback,
    input  logic                                   rdWriteEnable_execute,
    input  logic                                   rdWriteEnable_memory,
    input  logic                                   rdWriteEnable_writeback,
    input  logic [XLEN-1:0]                        aluResult_memory,
    input  logic [XLEN-1:0]                        rd_writebackEnd,
    input  logic                                   longOpIssue_decode,
    input  logic                                   pcCTWriteEnable,
    input  logic                                   longOpDone,
    input  logic [REG_ADDR_WIDTH-1:0]              longOpDoneAddr,
    output logic                                   stall_fetch,
    output logic                                   stall_decode,
    output logic                                   flush_decode,
    output logic                                   flush_execute,
    output logic                                   bypassRS1_execute,
    output logic                                   bypassRS2_execute,
    output logic [XLEN-1:0]                        bypassValueRS1_execute,
    output logic [XLEN-1:0]                        bypassValueRS2_execute,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstandingCount,
    output logic                                   scoreboardError,
    output logic                                   scoreboardTimeout
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_REGS - 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("jzjpcc_scoreboard_hazard_unit: illegal parameter combination");
    end

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                issue_accept;
    logic                done_valid;
    logic                data_stall;
    logic                waw_stall;
    logic                full_stall;
    logic                control_stall;
    logic                any_stall;

    // Stall terms read only current state, so issue_accept depending on stall_decode forms no loop.
    assign done_valid    = longOpDone && (longOpDoneAddr != '0) && pending[longOpDoneAddr];
    assign data_stall    = ((rs1Addr_decode != '0) && pending[rs1Addr_decode]) ||
                           ((rs2Addr_decode != '0) && pending[rs2Addr_decode]);
    assign waw_stall     = longOpIssue_decode && (rdAddr_decode != '0) && pending[rdAddr_decode];
    assign full_stall    = longOpIssue_decode && (outstandingCount == CW'(MAX_OUTSTANDING)) && !done_valid;
    assign control_stall = pcCTWriteEnable && rdWriteEnable_execute && (rdAddr_execute != '0) &&
                           ((rdAddr_execute == rs1Addr_decode) || (rdAddr_execute == rs2Addr_decode));
    assign any_stall     = data_stall || waw_stall || full_stall || control_stall;

    assign stall_fetch   = any_stall;
    assign stall_decode  = any_stall;
    assign flush_execute = any_stall;
    assign flush_decode  = pcCTWriteEnable && !any_stall;
    assign issue_accept  = longOpIssue_decode && !any_stall;

    // Clear before set so a same-register complete/reissue leaves the bit set.
    always_comb begin
        // NOTE: default assignment first so every path drives pending_next and no latch is inferred.
        pending_next = pending;
        if (done_valid)
            pending_next[longOpDoneAddr] = 1'b0;
        if (issue_accept && (rdAddr_decode != '0))
            pending_next[rdAddr_decode] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending          <= '0;
            outstandingCount <= '0;
            scoreboardError  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (issue_accept && !done_valid)
                outstandingCount <= outstandingCount + CW'(1);
            else if (done_valid && !issue_accept)
                outstandingCount <= outstandingCount - CW'(1);
            if (longOpDone && !done_valid)
                scoreboardError <= 1'b1;
        end
    end

    // Execute-stage bypass: memory stage is younger, so it wins over writeback.
    always_comb begin
        bypassRS1_execute      = 1'b0;
        bypassValueRS1_execute = '0;
        if (rs1Addr_execute != '0) begin
            if (rdWriteEnable_memory && (rs1Addr_execute == rdAddr_memory)) begin
                bypassRS1_execute      = 1'b1;
                bypassValueRS1_execute = aluResult_memory;
            end else if (rdWriteEnable_writeback && (rs1Addr_execute == rdAddr_writeback)) begin
                bypassRS1_execute      = 1'b1;
                bypassValueRS1_execute = rd_writebackEnd;
            end
        end
    end

    always_comb begin
        bypassRS2_execute      = 1'b0;
        bypassValueRS2_execute = '0;
        if (rs2Addr_execute != '0) begin
            if (rdWriteEnable_memory && (rs2Addr_execute == rdAddr_memory)) begin
                bypassRS2_execute      = 1'b1;
                bypassValueRS2_execute = aluResult_memory;
            end else if (rdWriteEnable_writeback && (rs2Addr_execute == rdAddr_writeback)) begin
                bypassRS2_execute      = 1'b1;
                bypassValueRS2_execute = rd_writebackEnd;
            end
        end
    end

`ifdef JZJPCC_SCOREBOARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] watchdog_count;
    logic          watchdog_active;

    // Counts consecutive cycles with work in flight but no completion of any kind.
    assign watchdog_active = (outstandingCount != '0) && !longOpDone;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            watchdog_count    <= '0;
            scoreboardTimeout <= 1'b0;
        end else begin
            if (!watchdog_active)
                watchdog_count <= '0;
            else if (watchdog_count != TW'(TIMEOUT_CYCLES))
                watchdog_count <= watchdog_count + TW'(1);
            if (watchdog_active && (watchdog_count == TW'(TIMEOUT_CYCLES - 1)))
                scoreboardTimeout <= 1'b1;
        end
    end
`else
    assign scoreboardTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_jzjpcc_scoreboard_hazard_unit.sv
// Directed self-checking bench for jzjpcc_scoreboard_hazard_unit (default parameters, watchdog limit 16).
module tb_jzjpcc_scoreboard_hazard_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   rs1Addr_decode, rs2Addr_decode, rdAddr_decode;
    logic [AW-1:0]   rs1Addr_execute, rs2Addr_execute, rdAddr_execute;
    logic [AW-1:0]   rdAddr_memory, rdAddr_writeback, longOpDoneAddr;
    logic            rdWriteEnable_execute, rdWriteEnable_memory, rdWriteEnable_writeback;
    logic [XLEN-1:0] aluResult_memory, rd_writebackEnd;
    logic            longOpIssue_decode, pcCTWriteEnable, longOpDone;
    logic            stall_fetch, stall_decode, flush_decode, flush_execute;
    logic            bypassRS1_execute, bypassRS2_execute;
    logic [XLEN-1:0] bypassValueRS1_execute, bypassValueRS2_execute;
    logic [2:0]      outstandingCount;
    logic            scoreboardError, scoreboardTimeout;

    int n_asserts = 0;
    int n_fail    = 0;

    jzjpcc_scoreboard_hazard_unit #(
        .XLEN(XLEN), .REG_ADDR_WIDTH(AW), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode), .rdAddr_decode(rdAddr_decode),
        .rs1Addr_execute(rs1Addr_execute), .rs2Addr_execute(rs2Addr_execute), .rdAddr_execute(rdAddr_execute),
        .rdAddr_memory(rdAddr_memory), .rdAddr_writeback(rdAddr_writeback),
        .rdWriteEnable_execute(rdWriteEnable_execute), .rdWriteEnable_memory(rdWriteEnable_memory),
        .rdWriteEnable_writeback(rdWriteEnable_writeback),
        .aluResult_memory(aluResult_memory), .rd_writebackEnd(rd_writebackEnd),
        .longOpIssue_decode(longOpIssue_decode), .pcCTWriteEnable(pcCTWriteEnable),
        .longOpDone(longOpDone), .longOpDoneAddr(longOpDoneAddr),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .bypassRS1_execute(bypassRS1_execute), .bypassRS2_execute(bypassRS2_execute),
        .bypassValueRS1_execute(bypassValueRS1_execute), .bypassValueRS2_execute(bypassValueRS2_execute),
        .outstandingCount(outstandingCount), .scoreboardError(scoreboardError),
        .scoreboardTimeout(scoreboardTimeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1-2 time units later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic done_op(input logic [AW-1:0] addr);
        longOpDone = 1'b1;
        longOpDoneAddr = addr;
        step();
        longOpDone = 1'b0;
        longOpDoneAddr = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        {rs1Addr_decode, rs2Addr_decode, rdAddr_decode} = '0;
        {rs1Addr_execute, rs2Addr_execute, rdAddr_execute} = '0;
        {rdAddr_memory, rdAddr_writeback, longOpDoneAddr} = '0;
        {rdWriteEnable_execute, rdWriteEnable_memory, rdWriteEnable_writeback} = '0;
        aluResult_memory = '0;
        rd_writebackEnd = '0;
        {longOpIssue_decode, pcCTWriteEnable, longOpDone} = '0;

        // Reset state
        #2;
        check("rst_count", 64'(outstandingCount), 64'd0);
        check("rst_error", 64'(scoreboardError), 64'd0);
        check("rst_timeout", 64'(scoreboardTimeout), 64'd0);
        check("rst_stall", 64'({stall_fetch, stall_decode, flush_execute, flush_decode}), 64'h0);
        check("rst_bypass", 64'({bypassRS1_execute, bypassRS2_execute}), 64'h0);
        step();
        reset_n = 1'b1;
        step();

        // RAW on a long-latency destination
        longOpIssue_decode = 1'b1;
        rdAddr_decode = 5'd5;
        settle();
        check("raw_issue_nostall", 64'(stall_decode), 64'd0);
        step();
        longOpIssue_decode = 1'b0;
        rdAddr_decode = '0;
        rs1Addr_decode = 5'd5;
        settle();
        check("raw_count1", 64'(outstandingCount), 64'd1);
        check("raw_stall_all", 64'({stall_fetch, stall_decode, flush_execute}), 64'h7);
        step();
        check("raw_stall_hold", 64'(stall_decode), 64'd1);
        longOpDone = 1'b1;
        longOpDoneAddr = 5'd5;
        settle();
        check("raw_stall_done_cycle", 64'(stall_decode), 64'd1);
        step();
        longOpDone = 1'b0;
        longOpDoneAddr = '0;
        settle();
        check("raw_stall_released", 64'(stall_decode), 64'd0);
        check("raw_count0", 64'(outstandingCount), 64'd0);
        check("raw_no_error", 64'(scoreboardError), 64'd0);
        rs1Addr_decode = '0;

        // Fill to MAX_OUTSTANDING, then full stall and same-cycle completion
        for (int i = 1; i <= 4; i++) begin
            longOpIssue_decode = 1'b1;
            rdAddr_decode = AW'(i);
            settle();
            check("fill_issue_nostall", 64'(stall_decode), 64'd0);
            step();
        end
        longOpIssue_decode = 1'b1;
        rdAddr_decode = 5'd6;
        settle();
        check("full_count4", 64'(outstandingCount), 64'd4);
        check("full_stall", 64'({stall_decode, flush_execute}), 64'h3);
        longOpDone = 1'b1;
        longOpDoneAddr = 5'd1;
        settle();
        check("full_done_accept", 64'(stall_decode), 64'd0);
        step();
        longOpIssue_decode = 1'b0;
        longOpDone = 1'b0;
        longOpDoneAddr = '0;
        rdAddr_decode = '0;
        rs1Addr_decode = 5'd6;
        settle();
        check("full_count_stays4", 64'(outstandingCount), 64'd4);
        check("full_r6_pending", 64'(stall_decode), 64'd1);
        rs1Addr_decode = 5'd1;
        settle();
        check("full_r1_cleared", 64'(stall_decode), 64'd0);
        rs1Addr_decode = '0;

        // Drain, with a write-after-write hazard checked part way
        done_op(5'd2);
        check("drain_count3", 64'(outstandingCount), 64'd3);
        longOpIssue_decode = 1'b1;
        rdAddr_decode = 5'd3;
        settle();
        check("waw_stall", 64'(stall_decode), 64'd1);
        longOpIssue_decode = 1'b0;
        rdAddr_decode = '0;
        done_op(5'd3);
        done_op(5'd4);
        done_op(5'd6);
        check("drain_count0", 64'(outstandingCount), 64'd0);
        check("drain_no_error", 64'(scoreboardError), 64'd0);

        // Bypass priority and register 0
        rs1Addr_execute = 5'd7;
        rs2Addr_execute = 5'd7;
        rdAddr_memory = 5'd7;
        rdAddr_writeback = 5'd7;
        rdWriteEnable_memory = 1'b1;
        rdWriteEnable_writeback = 1'b1;
        aluResult_memory = 32'hAAAA_1111;
        rd_writebackEnd = 32'hBBBB_2222;
        settle();
        check("byp_mem_wins_sel", 64'(bypassRS1_execute), 64'd1);
        check("byp_mem_wins_val", 64'(bypassValueRS1_execute), 64'hAAAA_1111);
        rdWriteEnable_memory = 1'b0;
        settle();
        check("byp_wb_val", 64'(bypassValueRS2_execute), 64'hBBBB_2222);
        check("byp_wb_sel", 64'(bypassRS2_execute), 64'd1);
        rs1Addr_execute = '0;
        rdAddr_memory = '0;
        rdAddr_writeback = '0;
        rdWriteEnable_memory = 1'b1;
        settle();
        check("byp_r0", 64'({bypassRS1_execute, bypassValueRS1_execute}), 64'h0);
        rs2Addr_execute = 5'd9;
        settle();
        check("byp_nomatch", 64'({bypassRS2_execute, bypassValueRS2_execute}), 64'h0);
        {rdWriteEnable_memory, rdWriteEnable_writeback} = '0;
        rs2Addr_execute = '0;

        // Control transfer while the branch target register is still in execute
        pcCTWriteEnable = 1'b1;
        rdWriteEnable_execute = 1'b1;
        rdAddr_execute = 5'd3;
        rs2Addr_decode = 5'd3;
        settle();
        check("ctl_stall", 64'({flush_decode, stall_decode}), 64'h1);
        step();
        rs2Addr_decode = 5'd4;
        settle();
        check("ctl_flush", 64'({flush_decode, stall_decode}), 64'h2);
        rdWriteEnable_execute = 1'b0;
        rs2Addr_decode = 5'd3;
        settle();
        check("ctl_no_we", 64'({flush_decode, stall_decode}), 64'h2);
        pcCTWriteEnable = 1'b0;
        rdAddr_execute = '0;
        rs2Addr_decode = '0;

        // Spurious completion, then reset mid-stream
        longOpDone = 1'b1;
        longOpDoneAddr = 5'd9;
        settle();
        check("err_before_edge", 64'(scoreboardError), 64'd0);
        step();
        longOpDone = 1'b0;
        longOpDoneAddr = '0;
        settle();
        check("err_set", 64'(scoreboardError), 64'd1);
        check("err_count_unchanged", 64'(outstandingCount), 64'd0);
        done_op(5'd0);
        step();
        check("err_sticky", 64'(scoreboardError), 64'd1);
        longOpIssue_decode = 1'b1;
        rdAddr_decode = 5'd8;
        step();
        longOpIssue_decode = 1'b0;
        rdAddr_decode = '0;
        rs1Addr_decode = 5'd8;
        settle();
        check("pre_rst_count", 64'(outstandingCount), 64'd1);
        check("pre_rst_stall", 64'(stall_decode), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", 64'({outstandingCount, scoreboardError, scoreboardTimeout}), 64'h0);
        check("mid_rst_no_stall", 64'(stall_decode), 64'd0);
        step();
        reset_n = 1'b1;
        rs1Addr_decode = '0;
        step();

        // Watchdog: one issue, no completion for TIMEOUT_CYCLES edges
        longOpIssue_decode = 1'b1;
        rdAddr_decode = 5'd10;
        step();
        longOpIssue_decode = 1'b0;
        rdAddr_decode = '0;
        for (int i = 0; i < 15; i++) step();
        check("wd_not_yet", 64'(scoreboardTimeout), 64'd0);
        step();
`ifdef JZJPCC_SCOREBOARD_TIMEOUT_EN
        check("wd_timeout", 64'(scoreboardTimeout), 64'd1);
`else
        check("wd_tied_off", 64'(scoreboardTimeout), 64'd0);
`endif
        check("wd_count1", 64'(outstandingCount), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/jzjpcc_scoreboard_hazard_unit.md
JZJPCC_SCOREBOARD_HAZARD_UNIT -- requirements
Module: jzjpcc_scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width; 2**REG_ADDR_WIDTH scoreboard entries.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight long-latency ops (1..2**REG_ADDR_WIDTH-1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit (used only with JZJPCC_SCOREBOARD_TIMEOUT_EN).
REQ-005 SHALL have ports: clock  in  1  single clock, rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: rs1Addr_decode, rs2Addr_decode, rdAddr_decode, rs1Addr_execute, rs2Addr_execute, rdAddr_execute, rdAddr_memory, rdAddr_writeback  in  REG_ADDR_WIDTH  stage register addresses.
REQ-007 SHALL have ports: rdWriteEnable_execute, rdWriteEnable_memory, rdWriteEnable_writeback  in  1  stage rd write enables.
REQ-008 SHALL have ports: aluResult_memory, rd_writebackEnd  in  XLEN  bypass source values.
REQ-009 SHALL have ports: longOpIssue_decode  in  1  decode holds a long-latency op (load, mul/div) writing rdAddr_decode; pcCTWriteEnable  in  1  control transfer taken.
REQ-010 SHALL have ports: longOpDone  in  1  long op completes this cycle; longOpDoneAddr  in  REG_ADDR_WIDTH  its rd.
REQ-011 SHALL have ports: stall_fetch, stall_decode, flush_decode, flush_execute  out  1  pipeline control.
REQ-012 SHALL have ports: bypassRS1_execute, bypassRS2_execute  out  1  select; bypassValueRS1_execute, bypassValueRS2_execute  out  XLEN  values.
REQ-013 SHALL have ports: outstandingCount  out  $clog2(MAX_OUTSTANDING+1)  in-flight ops; scoreboardError  out  1  sticky protocol error; scoreboardTimeout  out  1  sticky watchdog flag.

Function
REQ-014 SHALL hold a pending bit per register; bit 0 never set.
REQ-015 SHALL accept an issue when longOpIssue_decode && !stall_decode; at the next edge, set pending[rdAddr_decode] (if nonzero) and increment outstandingCount.
REQ-016 SHALL, on longOpDone with pending[longOpDoneAddr] set, clear that bit and decrement outstandingCount at the next edge.
REQ-017 SHALL treat simultaneous accepted issue and valid completion as count unchanged; same register: bit remains set.
REQ-018 SHALL, on longOpDone for register 0 or a non-pending register, leave state unchanged and set scoreboardError.
REQ-019 SHALL assert dataStall when a nonzero rs1Addr_decode/rs2Addr_decode is pending (completion-cycle included; resolves next cycle).
REQ-020 SHALL assert wawStall when longOpIssue_decode and rdAddr_decode (nonzero) is pending.
REQ-021 SHALL assert fullStall when longOpIssue_decode && outstandingCount==MAX_OUTSTANDING && no valid longOpDone this cycle.
REQ-022 SHALL assert controlStall when pcCTWriteEnable && rdWriteEnable_execute && nonzero rdAddr_execute equals rs1Addr_decode or rs2Addr_decode.
REQ-023 SHALL drive stall_fetch = stall_decode = flush_execute = OR of REQ-019..022 stalls; flush_decode = pcCTWriteEnable && !stall_decode.
REQ-024 SHALL bypass per execute source: nonzero addr matching rdAddr_memory with write enable selects aluResult_memory; else matching rdAddr_writeback selects rd_writebackEnd; else select 0, value 0. Memory wins.
REQ-025 SHALL keep bypass and stall outputs combinational (zero latency); scoreboard updates take one cycle.

Reset
REQ-026 SHALL, while reset_n low, asynchronously clear all pending bits, outstandingCount, scoreboardError, scoreboardTimeout and watchdog counter; reset mid-operation discards in-flight ops.
REQ-027 SHALL hold combinational outputs consistent with cleared state during reset (no scoreboard-induced stall).

Configuration
REQ-028 SHALL, with JZJPCC_SCOREBOARD_TIMEOUT_EN defined, count cycles with outstandingCount>0 and no longOpDone, reset the count on any longOpDone or count 0, and set sticky scoreboardTimeout on reaching TIMEOUT_CYCLES.
REQ-029 SHALL, without JZJPCC_SCOREBOARD_TIMEOUT_EN, tie scoreboardTimeout to 0 and omit the counter.

Verification
REQ-030 SHALL cover: issue rd=5, next cycle rs1Addr_decode=5 -> stall_decode=1 until cycle after longOpDone addr 5, outstandingCount 1->0.
REQ-031 SHALL cover: MAX_OUTSTANDING=4, issue rd 1..4, fifth issue rd=6 -> fullStall; same-cycle longOpDone addr 1 -> accepted, count stays 4.
REQ-032 SHALL cover: rs1Addr_execute=7 matching rdAddr_memory and rdAddr_writeback, both enabled -> bypassValueRS1_execute=aluResult_memory; rs=0 -> bypass 0.
REQ-033 SHALL cover: pcCTWriteEnable=1, rdAddr_execute=3 enabled, rs2Addr_decode=3 -> flush_decode=0, stall_decode=1; next cycle clear -> flush_decode=1.
REQ-034 SHALL cover: longOpDone addr 9 not pending -> scoreboardError=1 sticky; reset_n pulse mid-stream -> all state 0.
REQ-035 SHALL cover (macro on, TIMEOUT_CYCLES=16): one issue, no completion 16 cycles -> scoreboardTimeout=1.
